// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Optional message locking (keep the owner until req_last) is enabled by UART_ARB_MSG_LOCK_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   timeout_err
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]   owner, owner_d;
    logic [NUM_REQ-1:0] grant_d, req_ready_d;
    logic [7:0]         tx_data_d;
    logic               tx_start_d, timeout_err_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt, cnt_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    int unsigned        cand;
    logic [7:0]         req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    // Round-robin search: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req_valid[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            grant       <= '0;
            req_ready   <= '0;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            last_q      <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_d;
            rr_ptr      <= rr_ptr_d;
            owner       <= owner_d;
            grant       <= grant_d;
            req_ready   <= req_ready_d;
            tx_data     <= tx_data_d;
            tx_start    <= tx_start_d;
            timeout_err <= timeout_err_d;
            last_q      <= last_d;
            cnt         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state;
        rr_ptr_d      = rr_ptr;
        owner_d       = owner;
        grant_d       = grant;
        req_ready_d   = '0;
        tx_data_d     = tx_data;
        tx_start_d    = 1'b0;
        timeout_err_d = 1'b0;
        last_d        = last_q;
        cnt_d         = cnt;

        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_d  = NUM_REQ'(1) << win_idx;
                    owner_d  = win_idx;
                    rr_ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    state_d  = ACCEPT;
                end
            end
            ACCEPT: begin
                // Owner may have withdrawn its byte; release without a strobe
                if (req_valid[owner]) begin
                    req_ready_d = grant;
                    tx_data_d   = req_bytes[owner];
                    last_d      = req_last[owner];
                    state_d     = START;
                end else begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            START: begin
                tx_start_d = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    grant_d       = '0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef UART_ARB_MSG_LOCK_EN
                    if (!last_q) begin
                        state_d = ACCEPT;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
`else
                    grant_d = '0;
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

`ifndef UART_ARB_MSG_LOCK_EN
    logic unused_last;
    assign unused_last = last_q;
`endif

endmodule
